ahbl_arb_2m: RTL and testbench

Two-master to one-slave AHB-Lite arbiter. It sits directly downstream of the single-channel DMA controller's master port (M1) and the CPU's master port (M0). It merges them onto the single system AHB-Lite bus that feeds the slave decoder. Each master's address phase is accepted into a per-master pending register and replayed on the shared bus under round-robin or fixed-priority arbitration. No master HREADY output depends combinationally on that master's own HTRANS, because the DMA master gates HTRANS with HREADY.

---
 rtl/ahbl_arb_2m.sv | 129 ++++++++++++
 tb/tb_ahbl_arb_2m.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahbl_arb_2m.sv
// Two-master to one-slave AHB-Lite arbiter: each master's address phase is
// parked in a pending register and replayed on the shared bus.
module ahbl_arb_2m #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] M0_HADDR,
  input  logic [1:0]  M0_HTRANS,
  input  logic        M0_HWRITE,
  input  logic [2:0]  M0_HSIZE,
  input  logic [31:0] M0_HWDATA,
  output logic [31:0] M0_HRDATA,
  output logic        M0_HREADY,
  input  logic [31:0] M1_HADDR,
  input  logic [1:0]  M1_HTRANS,
  input  logic        M1_HWRITE,
  input  logic [2:0]  M1_HSIZE,
  input  logic [31:0] M1_HWDATA,
  output logic [31:0] M1_HRDATA,
  output logic        M1_HREADY,
  output logic [31:0] S_HADDR,
  output logic [1:0]  S_HTRANS,
  output logic        S_HWRITE,
  output logic [2:0]  S_HSIZE,
  output logic [31:0] S_HWDATA,
  input  logic [31:0] S_HRDATA,
  input  logic        S_HREADY
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 3;
  localparam int unsigned TW = 2;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          write;
    logic [SW-1:0] size;
  } addr_ph_t;

  logic [1:0] pend;
  addr_ph_t   req_q [2];
  logic       dv;
  logic       own;
  logic       last;

  logic [1:0] cap_c;
  logic [1:0] pend_nxt_c;
  logic       grant_c;
  logic       issue_c;
  addr_ph_t   sel_c;

  // HTRANS[0] only distinguishes SEQ from NONSEQ and IDLE from BUSY
  logic unused_htrans0;
  assign unused_htrans0 = M0_HTRANS[0] ^ M1_HTRANS[0];

  assign M0_HRDATA = S_HRDATA;
  assign M1_HRDATA = S_HRDATA;

  // Ready is a function of registers and S_HREADY only, never of HTRANS
  assign M0_HREADY = (dv && !own) ? S_HREADY : !pend[0];
  assign M1_HREADY = (dv &&  own) ? S_HREADY : !pend[1];

  assign cap_c[0] = M0_HTRANS[1] & M0_HREADY;
  assign cap_c[1] = M1_HTRANS[1] & M1_HREADY;

  assign issue_c = |pend;

  always_comb begin
    grant_c = 1'b0;
    unique case (pend)
      2'b01:   grant_c = 1'b0;
      2'b10:   grant_c = 1'b1;
      2'b11:   grant_c = RR_EN ? ~last : 1'b0;
      default: grant_c = 1'b0;
    endcase
  end

  always_comb begin
    pend_nxt_c = pend;
    if (S_HREADY && issue_c) begin
      pend_nxt_c[grant_c] = 1'b0;
    end
    pend_nxt_c = pend_nxt_c | cap_c;
  end

  always_comb begin
    sel_c = '0;
    if (issue_c) begin
      sel_c = req_q[grant_c];
    end
  end

  assign S_HTRANS = issue_c ? TW'(2'b10) : TW'(2'b00);
  assign S_HADDR  = sel_c.addr;
  assign S_HWRITE = sel_c.write;
  assign S_HSIZE  = sel_c.size;
  assign S_HWDATA = dv ? (own ? M1_HWDATA : M0_HWDATA) : DW'(0);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend     <= '0;
      dv       <= 1'b0;
      own      <= 1'b0;
      last     <= 1'b1;
      req_q[0] <= '0;
      req_q[1] <= '0;
    end else begin
      pend <= pend_nxt_c;
      if (S_HREADY) begin
        if (issue_c) begin
          own  <= grant_c;
          last <= grant_c;
          dv   <= 1'b1;
        end else begin
          dv   <= 1'b0;
        end
      end
      if (cap_c[0]) begin
        req_q[0] <= '{addr: M0_HADDR, write: M0_HWRITE, size: M0_HSIZE};
      end
      if (cap_c[1]) begin
        req_q[1] <= '{addr: M1_HADDR, write: M1_HWRITE, size: M1_HSIZE};
      end
    end
  end

endmodule

// File: tb/tb_ahbl_arb_2m.sv
// Bench for ahbl_arb_2m: a round-robin and a fixed-priority instance share the
// same masters; a transaction-level model checks both every cycle.
module tb_ahbl_arb_2m;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] M0_HADDR, M1_HADDR, M0_HWDATA, M1_HWDATA;
  logic [1:0]  M0_HTRANS, M1_HTRANS;
  logic        M0_HWRITE, M1_HWRITE;
  logic [2:0]  M0_HSIZE, M1_HSIZE;
  logic [31:0] tb_rdata;
  logic        tb_ready;
  logic [31:0] s_hrdata;
  logic        s_hready;

  // index 0: RR_EN=1 instance, index 1: RR_EN=0 instance
  logic [1:0][31:0] m0_hrdata, m1_hrdata, s_haddr, s_hwdata;
  logic [1:0]       m0_hready, m1_hready, s_hwrite;
  logic [1:0][1:0]  s_htrans;
  logic [1:0][2:0]  s_hsize;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_issue = 0;
  logic chk_en = 1'b0;
  logic mem_en = 1'b0;

  always #5 HCLK = ~HCLK;

  ahbl_arb_2m #(.RR_EN(1'b1)) u_rr (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE), .M0_HSIZE(M0_HSIZE),
    .M0_HWDATA(M0_HWDATA), .M0_HRDATA(m0_hrdata[0]), .M0_HREADY(m0_hready[0]),
    .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE), .M1_HSIZE(M1_HSIZE),
    .M1_HWDATA(M1_HWDATA), .M1_HRDATA(m1_hrdata[0]), .M1_HREADY(m1_hready[0]),
    .S_HADDR(s_haddr[0]), .S_HTRANS(s_htrans[0]), .S_HWRITE(s_hwrite[0]), .S_HSIZE(s_hsize[0]),
    .S_HWDATA(s_hwdata[0]), .S_HRDATA(s_hrdata), .S_HREADY(s_hready)
  );

  ahbl_arb_2m #(.RR_EN(1'b0)) u_fp (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE), .M0_HSIZE(M0_HSIZE),
    .M0_HWDATA(M0_HWDATA), .M0_HRDATA(m0_hrdata[1]), .M0_HREADY(m0_hready[1]),
    .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE), .M1_HSIZE(M1_HSIZE),
    .M1_HWDATA(M1_HWDATA), .M1_HRDATA(m1_hrdata[1]), .M1_HREADY(m1_hready[1]),
    .S_HADDR(s_haddr[1]), .S_HTRANS(s_htrans[1]), .S_HWRITE(s_hwrite[1]), .S_HSIZE(s_hsize[1]),
    .S_HWDATA(s_hwdata[1]), .S_HRDATA(s_hrdata), .S_HREADY(s_hready)
  );

  // ---------------- memory slave used by the DMA copy ----------------
  logic [31:0] mem [8];
  logic [1:0]  sl_cnt = '0;
  logic        sl_dv = 1'b0;
  logic        sl_wr = 1'b0;
  logic [31:0] sl_addr = '0;

  function automatic int midx(input logic [31:0] a);
    return int'({a[12], a[3:2]});
  endfunction

  always @(posedge HCLK) begin
    sl_cnt <= (sl_cnt == 2'd2) ? 2'd0 : sl_cnt + 2'd1;
    if (!mem_en) begin
      sl_dv <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        mem[i]   <= 32'hC0DE_0000 + 32'(i);
        mem[i+4] <= 32'h0;
      end
    end else if (s_hready) begin
      if (sl_dv && sl_wr) mem[midx(sl_addr)] <= s_hwdata[0];
      sl_dv   <= s_htrans[0][1];
      sl_addr <= s_haddr[0];
      sl_wr   <= s_hwrite[0];
    end
  end

  assign s_hready = mem_en ? (sl_cnt != 2'd2) : tb_ready;
  assign s_hrdata = mem_en ? ((sl_dv && !sl_wr) ? mem[midx(sl_addr)] : 32'h0) : tb_rdata;

  // ---------------- transaction-level reference model ----------------
  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
  } rq_t;

  logic [1:0][1:0] queued;   // [inst][master]: request accepted, not yet on the bus
  rq_t  [1:0][1:0] rq;
  logic [1:0]      in_data;  // a shared-bus data phase is in flight
  logic [1:0]      owner;
  logic [1:0]      prev;     // most recent winner

  function automatic logic win(input int k);
    if (queued[k][0] && queued[k][1]) return (k == 0) ? !prev[k] : 1'b0;
    return !queued[k][0];
  endfunction

  function automatic logic rdy(input int k, input int i);
    if (in_data[k] && owner[k] == 1'(i)) return s_hready;
    return !queued[k][i];
  endfunction

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      queued  <= '0;
      rq      <= '0;
      in_data <= '0;
      owner   <= '0;
      prev    <= 2'b11;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (s_hready && (queued[k] != 2'b00)) begin
          queued[k][win(k)] <= 1'b0;
          in_data[k]        <= 1'b1;
          owner[k]          <= win(k);
          prev[k]           <= win(k);
        end else if (s_hready) begin
          in_data[k] <= 1'b0;
        end
        if (M0_HTRANS[1] && rdy(k, 0)) begin
          queued[k][0] <= 1'b1;
          rq[k][0]     <= {M0_HADDR, M0_HWRITE, M0_HSIZE};
        end
        if (M1_HTRANS[1] && rdy(k, 1)) begin
          queued[k][1] <= 1'b1;
          rq[k][1]     <= {M1_HADDR, M1_HWRITE, M1_HSIZE};
        end
      end
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model
  initial begin
    rq_t         e_sel;
    logic [31:0] e_wd;
    forever begin
      @(negedge HCLK);
      if (chk_en) begin
        for (int k = 0; k < 2; k++) begin
          e_sel = (queued[k] != 2'b00) ? rq[k][win(k)] : '0;
          e_wd  = in_data[k] ? (owner[k] ? M1_HWDATA : M0_HWDATA) : 32'h0;
          cmp($sformatf("i%0d S_HTRANS", k), 32'(s_htrans[k]), (queued[k] != 2'b00) ? 32'd2 : 32'd0);
          cmp($sformatf("i%0d S_HADDR", k), s_haddr[k], e_sel.addr);
          cmp($sformatf("i%0d S_HWRITE", k), 32'(s_hwrite[k]), 32'(e_sel.wr));
          cmp($sformatf("i%0d S_HSIZE", k), 32'(s_hsize[k]), 32'(e_sel.size));
          cmp($sformatf("i%0d S_HWDATA", k), s_hwdata[k], e_wd);
          cmp($sformatf("i%0d M0_HREADY", k), 32'(m0_hready[k]), 32'(rdy(k, 0)));
          cmp($sformatf("i%0d M1_HREADY", k), 32'(m1_hready[k]), 32'(rdy(k, 1)));
          cmp($sformatf("i%0d M0_HRDATA", k), m0_hrdata[k], s_hrdata);
          cmp($sformatf("i%0d M1_HRDATA", k), m1_hrdata[k], s_hrdata);
        end
        if (mem_en && s_htrans[0] == 2'b10 && s_hready) n_issue++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  task automatic step;
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset;
    HRESETn = 1'b0;
    M0_HTRANS = 2'b00; M1_HTRANS = 2'b00;
    tb_ready = 1'b1; tb_rdata = 32'h0;
    step; step;
    #3;
    for (int k = 0; k < 2; k++) begin
      cmp("rst S_HTRANS", 32'(s_htrans[k]), 32'd0);
      cmp("rst S_HADDR", s_haddr[k], 32'h0);
      cmp("rst S_HWDATA", s_hwdata[k], 32'h0);
      cmp("rst M0_HREADY", 32'(m0_hready[k]), 32'd1);
      cmp("rst M1_HREADY", 32'(m1_hready[k]), 32'd1);
    end
    step;
    HRESETn = 1'b1;
  endtask

  task automatic dma_xfer(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                          output logic [31:0] rd);
    logic done;
    rd = 32'h0;
    M1_HADDR = a; M1_HWRITE = wr; M1_HSIZE = 3'd2; M1_HTRANS = 2'b10;
    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      #3; done = m1_hready[0];
      step;
    end
    cmp("dma address accepted", 32'(done), 32'd1);
    M1_HTRANS = 2'b00; M1_HWDATA = wd;
    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      #3;
      if (m1_hready[0]) begin done = 1'b1; rd = m1_hrdata[0]; end
      step;
    end
    cmp("dma data completed", 32'(done), 32'd1);
  endtask

  initial begin
    logic [31:0] t3 [6];
    logic [1:0]  t4t [6];
    logic [31:0] t4a [6];
    logic        r0, r1;
    int          n_lo, n_wd, base;
    logic [31:0] d, d2;

    t3  = '{32'h100, 32'h200, 32'h104, 32'h204, 32'h108, 32'h208};
    t4t = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd2, 2'd0};
    t4a = '{32'h300, 32'h900, 32'h304, 32'h0, 32'h308, 32'h0};

    M0_HADDR = '0; M1_HADDR = '0; M0_HWDATA = '0; M1_HWDATA = '0;
    M0_HWRITE = 1'b0; M1_HWRITE = 1'b0; M0_HSIZE = 3'd2; M1_HSIZE = 3'd2;
    r0 = 1'b0; r1 = 1'b0;
    do_reset();
    chk_en = 1'b1;

    // single read by M1
    M1_HADDR = 32'h2000_0010; M1_HWRITE = 1'b0; M1_HSIZE = 3'd2; M1_HTRANS = 2'b10;
    #3 cmp("t1 M1_HREADY N", 32'(m1_hready[0]), 32'd1);
    step;
    M1_HTRANS = 2'b00;
    #3;
    cmp("t1 S_HTRANS N+1", 32'(s_htrans[0]), 32'd2);
    cmp("t1 S_HADDR N+1", s_haddr[0], 32'h2000_0010);
    cmp("t1 M1_HREADY N+1", 32'(m1_hready[0]), 32'd0);
    cmp("t1 M0_HREADY N+1", 32'(m0_hready[0]), 32'd1);
    step;
    tb_rdata = 32'hCAFE_F00D;
    #3;
    cmp("t1 M1_HREADY N+2", 32'(m1_hready[0]), 32'd1);
    cmp("t1 M1_HRDATA N+2", m1_hrdata[0], 32'hCAFE_F00D);
    cmp("t1 M0_HREADY N+2", 32'(m0_hready[0]), 32'd1);
    step;
    tb_rdata = 32'h0;
    repeat (2) step;

    // M0 write with three slave wait states
    M0_HADDR = 32'h4000_0000; M0_HWRITE = 1'b1; M0_HSIZE = 3'd2; M0_HTRANS = 2'b10;
    step;
    M0_HTRANS = 2'b00; M0_HWDATA = 32'hA5A5_0001;
    n_lo = 0; n_wd = 0;
    for (int c = 1; c <= 8; c++) begin
      tb_ready = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
      #3;
      if (!m0_hready[0]) n_lo++;
      if (s_hwdata[0] == 32'hA5A5_0001) n_wd++;
      step;
    end
    cmp("t2 M0_HREADY low cycles", 32'(n_lo), 32'd4);
    cmp("t2 S_HWDATA valid cycles", 32'(n_wd), 32'd4);
    tb_ready = 1'b1; M0_HWDATA = '0; M0_HWRITE = 1'b0;
    step;

    // simultaneous continuous requests, round-robin
    do_reset();
    M0_HADDR = 32'h100; M1_HADDR = 32'h200; M0_HWRITE = 1'b0; M1_HWRITE = 1'b0;
    M0_HTRANS = 2'b10; M1_HTRANS = 2'b10;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) begin
        if (r0) M0_HADDR = M0_HADDR + 32'd4;
        if (r1) M1_HADDR = M1_HADDR + 32'd4;
      end
      #3;
      r0 = m0_hready[0]; r1 = m1_hready[0];
      if (c > 0) cmp($sformatf("t3 rr issue c%0d", c), s_haddr[0], t3[c-1]);
      step;
    end
    M0_HTRANS = 2'b00; M1_HTRANS = 2'b00;
    repeat (6) step;

    // fixed priority: M0 streams, M1 asks once
    do_reset();
    M0_HADDR = 32'h300; M0_HWRITE = 1'b0; M0_HTRANS = 2'b10;
    r0 = 1'b0;
    for (int c = 0; c < 7; c++) begin
      if (c > 0 && r0) M0_HADDR = M0_HADDR + 32'd4;
      if (c == 1) begin M1_HADDR = 32'h900; M1_HWRITE = 1'b0; M1_HTRANS = 2'b10; end
      if (c == 2) M1_HTRANS = 2'b00;
      #3;
      r0 = m0_hready[1];
      if (c > 0) begin
        cmp($sformatf("t4 fp htrans c%0d", c), 32'(s_htrans[1]), 32'(t4t[c-1]));
        cmp($sformatf("t4 fp haddr c%0d", c), s_haddr[1], t4a[c-1]);
      end
      step;
    end
    M0_HTRANS = 2'b00;
    repeat (6) step;

    // DMA copy of four words through M1 against the memory slave
    do_reset();
    mem_en = 1'b1;
    base = n_issue;
    for (int i = 0; i < 4; i++) begin
      dma_xfer(32'h2000_0000 + 32'(4*i), 1'b0, 32'h0, d);
      dma_xfer(32'h2000_1000 + 32'(4*i), 1'b1, d, d2);
    end
    step; step;
    cmp("t5 address phases issued", 32'(n_issue - base), 32'd8);
    for (int i = 0; i < 4; i++)
      cmp($sformatf("t5 dst word %0d", i), mem[4+i], 32'hC0DE_0000 + 32'(i));
    mem_en = 1'b0;
    step;

    // reset during an M1 write with M0 pending
    do_reset();
    M1_HADDR = 32'h50; M1_HWRITE = 1'b1; M1_HTRANS = 2'b10;
    step;
    M1_HTRANS = 2'b00; M1_HWDATA = 32'h1234_5678;
    M0_HADDR = 32'h70; M0_HWRITE = 1'b0; M0_HTRANS = 2'b10;
    step;
    M0_HTRANS = 2'b00; tb_ready = 1'b0;
    #1;
    cmp("t6 M0 pending HREADY", 32'(m0_hready[0]), 32'd0);
    cmp("t6 M0 address on bus", s_haddr[0], 32'h70);
    cmp("t6 M1 write data", s_hwdata[0], 32'h1234_5678);
    HRESETn = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      cmp("t6 rst S_HTRANS", 32'(s_htrans[k]), 32'd0);
      cmp("t6 rst M0_HREADY", 32'(m0_hready[k]), 32'd1);
      cmp("t6 rst M1_HREADY", 32'(m1_hready[k]), 32'd1);
      cmp("t6 rst S_HWDATA", s_hwdata[k], 32'h0);
    end
    step; step;
    HRESETn = 1'b1; tb_ready = 1'b1;
    M1_HADDR = 32'h60; M1_HWRITE = 1'b0; M1_HTRANS = 2'b10;
    step;
    M1_HTRANS = 2'b00;
    #3;
    cmp("t6 fresh S_HTRANS", 32'(s_htrans[0]), 32'd2);
    cmp("t6 fresh S_HADDR", s_haddr[0], 32'h60);
    repeat (4) step;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
